// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I datapath and its main control FSM.
// master = datapath side (supplies instruction fields/flags), slave = controller.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] f3;
    logic       zero;
    logic       neg;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [3:0] state;

    modport master (
        output op, f3, zero, neg,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_write, alu_op, state
    );

    modport slave (
        input  op, f3, zero, neg,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_write, alu_op, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/mem/wb.
// Outputs are combinational from state (plus flags in BRANCH); no backpressure, one state per clock.
module multicycle_controller (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.slave bus
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    state_t     cur, nxt;
    logic       pcw, adr, memw, irw, rw, taken;
    logic [1:0] rs, sa, sb, aop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= S_FETCH;
        else      cur <= nxt;
    end

    always_comb begin
        taken = 1'b0;
        case (bus.f3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = !bus.zero;
            3'b100:  taken = bus.neg;
            3'b101:  taken = !bus.neg;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        nxt  = S_FETCH;
        pcw  = 1'b0;
        adr  = 1'b0;
        memw = 1'b0;
        irw  = 1'b0;
        rw   = 1'b0;
        rs   = 2'b00;
        sa   = 2'b00;
        sb   = 2'b00;
        aop  = 2'b00;
        case (cur)
            S_FETCH: begin
                irw = 1'b1;
                sb  = 2'b10;
                rs  = 2'b10;
                pcw = 1'b1;
                nxt = S_DECODE;
            end
            S_DECODE: begin
                // OldPC+imm lands in ALUOut here, ready as a branch/jal target
                sa = 2'b01;
                sb = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_R:              nxt = S_EXECR;
                    OP_I:              nxt = S_EXECI;
                    OP_BR:             nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    OP_JALR:           nxt = S_JALR1;
                    OP_LUI:            nxt = S_LUI;
                    default:           nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                sa  = 2'b10;
                sb  = 2'b01;
                nxt = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr = 1'b1;
                nxt = S_MEMWB;
            end
            S_MEMWB: begin
                rs = 2'b01;
                rw = 1'b1;
            end
            S_MEMWRITE: begin
                adr  = 1'b1;
                memw = 1'b1;
            end
            S_EXECR: begin
                sa  = 2'b10;
                aop = 2'b10;
                nxt = S_ALUWB;
            end
            S_EXECI: begin
                sa  = 2'b10;
                sb  = 2'b01;
                aop = 2'b11;
                nxt = S_ALUWB;
            end
            S_ALUWB: rw = 1'b1;
            S_BRANCH: begin
                sa  = 2'b10;
                aop = 2'b01;
                pcw = taken;
            end
            S_JAL, S_JALR2: begin
                sa  = 2'b01;
                sb  = 2'b10;
                pcw = 1'b1;
                nxt = S_ALUWB;
            end
            S_JALR1: begin
                sa  = 2'b10;
                sb  = 2'b01;
                nxt = S_JALR2;
            end
            S_LUI: begin
                rs = 2'b11;
                rw = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_LOAD, OP_I, OP_JALR: bus.imm_src = 3'b000;
            OP_STORE:               bus.imm_src = 3'b001;
            OP_BR:                  bus.imm_src = 3'b010;
            OP_JAL:                 bus.imm_src = 3'b011;
            OP_LUI:                 bus.imm_src = 3'b100;
            default:                bus.imm_src = 3'b000;
        endcase
    end

    // Reset already pins the state to FETCH; the strobes alone need gating.
    assign bus.pc_write   = pcw  & rst;
    assign bus.ir_write   = irw  & rst;
    assign bus.mem_write  = memw & rst;
    assign bus.reg_write  = rw   & rst;
    assign bus.adr_src    = adr;
    assign bus.result_src = rs;
    assign bus.alu_src_a  = sa;
    assign bus.alu_src_b  = sb;
    assign bus.alu_op     = aop;
    assign bus.state      = cur;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream checked cycle-by-cycle against an instruction-level model.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    multicycle_controller_if bus ();
    multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    logic [6:0] legal [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                              7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    int seq [5];
    int seq_n;

    // Instruction-level model: the list of steps each opcode walks through.
    task automatic set_seq(input logic [6:0] o);
        seq = '{0, 1, 0, 0, 0};
        case (o)
            7'b0000011: begin seq[2] = 2;  seq[3] = 3;  seq[4] = 4; seq_n = 5; end
            7'b0100011: begin seq[2] = 2;  seq[3] = 5;  seq_n = 4; end
            7'b0110011: begin seq[2] = 6;  seq[3] = 8;  seq_n = 4; end
            7'b0010011: begin seq[2] = 7;  seq[3] = 8;  seq_n = 4; end
            7'b1100011: begin seq[2] = 9;  seq_n = 3; end
            7'b1101111: begin seq[2] = 10; seq[3] = 8;  seq_n = 4; end
            7'b1100111: begin seq[2] = 11; seq[3] = 12; seq[4] = 8; seq_n = 5; end
            7'b0110111: begin seq[2] = 13; seq_n = 3; end
            default:    seq_n = 2;
        endcase
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == 7'b0000011 || o == 7'b0010011 || o == 7'b1100111) return 3'd0;
        if (o == 7'b0100011) return 3'd1;
        if (o == 7'b1100011) return 3'd2;
        if (o == 7'b1101111) return 3'd3;
        if (o == 7'b0110111) return 3'd4;
        return 3'd0;
    endfunction

    function automatic ctrl_t model_ctrl(input int s, input logic [6:0] o, input logic [2:0] f,
                                         input logic z, input logic n);
        ctrl_t c;
        logic  tk;
        c = '0;
        c.imm_src = imm_of(o);
        tk = (f == 3'd0 && z) || (f == 3'd1 && !z) || (f == 3'd4 && n) || (f == 3'd5 && !n);
        case (s)
            0:  begin c.ir_write = 1; c.alu_src_b = 2; c.result_src = 2; c.pc_write = 1; end
            1:  begin c.alu_src_a = 1; c.alu_src_b = 1; end
            2:  begin c.alu_src_a = 2; c.alu_src_b = 1; end
            3:  c.adr_src = 1;
            4:  begin c.result_src = 1; c.reg_write = 1; end
            5:  begin c.adr_src = 1; c.mem_write = 1; end
            6:  begin c.alu_src_a = 2; c.alu_op = 2; end
            7:  begin c.alu_src_a = 2; c.alu_src_b = 1; c.alu_op = 3; end
            8:  c.reg_write = 1;
            9:  begin c.alu_src_a = 2; c.alu_op = 1; c.pc_write = tk; end
            10, 12: begin c.alu_src_a = 1; c.alu_src_b = 2; c.pc_write = 1; end
            11: begin c.alu_src_a = 2; c.alu_src_b = 1; end
            13: begin c.result_src = 3; c.reg_write = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctrl_t dut_ctrl();
        ctrl_t c;
        c.pc_write   = bus.pc_write;
        c.adr_src    = bus.adr_src;
        c.mem_write  = bus.mem_write;
        c.ir_write   = bus.ir_write;
        c.result_src = bus.result_src;
        c.alu_src_a  = bus.alu_src_a;
        c.alu_src_b  = bus.alu_src_b;
        c.imm_src    = bus.imm_src;
        c.reg_write  = bus.reg_write;
        c.alu_op     = bus.alu_op;
        return c;
    endfunction

    task automatic lit_check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_cycle(input int s);
        ctrl_t e, a;
        e = model_ctrl(s, bus.op, bus.f3, bus.zero, bus.neg);
        a = dut_ctrl();
        tests++;
        if (bus.state !== 4'(s)) begin
            fails++;
            $display("FAIL state op=%b: got %0d expected %0d", bus.op, bus.state, s);
        end
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL ctrl state=%0d op=%b: got %h expected %h", s, bus.op, a, e);
        end
    endtask

    // Entered and left at posedge+1 with the DUT in FETCH.
    task automatic run_instr(input logic [6:0] o, input bit rnd,
                             input logic [2:0] f, input logic z, input logic n);
        bus.op = o;
        set_seq(o);
        for (int i = 0; i < seq_n; i++) begin
            if (rnd) begin
                bus.f3   = 3'($urandom_range(0, 7));
                bus.zero = 1'($urandom_range(0, 1));
                bus.neg  = 1'($urandom_range(0, 1));
            end else begin
                bus.f3 = f; bus.zero = z; bus.neg = n;
            end
            #1;
            check_cycle(seq[i]);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic measure_cpi(input logic [6:0] o, input int exp, input string nm);
        int k;
        bus.op = o;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (bus.state != 4'd0 && k < 12);
        lit_check(nm, k, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        ctrl_t rst_exp;
        logic [6:0] o;
        bus.op = 7'b0110011; bus.f3 = 3'd0; bus.zero = 1'b0; bus.neg = 1'b0;
        rst_exp = '0;
        rst_exp.result_src = 2'b10;
        rst_exp.alu_src_b  = 2'b10;

        repeat (3) begin
            @(negedge clk);
            lit_check("reset_state", int'(bus.state), 0);
            tests++;
            if (dut_ctrl() !== rst_exp) begin
                fails++;
                $display("FAIL reset_ctrl: got %h expected %h", dut_ctrl(), rst_exp);
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        lit_check("first_fetch_ir_write", int'(bus.ir_write), 1);
        lit_check("first_fetch_pc_write", int'(bus.pc_write), 1);
        @(posedge clk);
        #1;
        lit_check("after_release_decode", int'(bus.state), 1);
        @(posedge clk);
        #1;
        lit_check("rtype_exec_state", int'(bus.state), 6);
        lit_check("rtype_exec_alu_op", int'(bus.alu_op), 2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        run_instr(7'b0110011, 1, 0, 0, 0);
        run_instr(7'b0000011, 1, 0, 0, 0);
        run_instr(7'b0100011, 1, 0, 0, 0);
        run_instr(7'b1100011, 0, 3'b000, 1'b1, 1'b0);
        run_instr(7'b1100011, 0, 3'b000, 1'b0, 1'b1);
        run_instr(7'b1100011, 0, 3'b100, 1'b0, 1'b1);
        run_instr(7'b1100011, 0, 3'b010, 1'b1, 1'b1);
        run_instr(7'b1101111, 1, 0, 0, 0);
        run_instr(7'b1100111, 1, 0, 0, 0);
        run_instr(7'b0110111, 1, 0, 0, 0);
        run_instr(7'b1111111, 1, 0, 0, 0);

        measure_cpi(7'b0000011, 5, "cpi_lw");
        measure_cpi(7'b1100111, 5, "cpi_jalr");
        measure_cpi(7'b0100011, 4, "cpi_sw");
        measure_cpi(7'b0010011, 4, "cpi_itype");
        measure_cpi(7'b1100011, 3, "cpi_branch");
        measure_cpi(7'b0110111, 3, "cpi_lui");
        measure_cpi(7'b1111111, 2, "cpi_illegal");

        bus.op = 7'b1101111;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        lit_check("jal_state", int'(bus.state), 10);
        lit_check("jal_imm_src", int'(bus.imm_src), 3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) o = 7'($urandom);
            else o = legal[$urandom_range(0, 7)];
            run_instr(o, 1, 0, 0, 0);
        end

        // Asynchronous reset while a store is strobing memory.
        bus.op = 7'b0100011;
        repeat (3) @(posedge clk);
        #2;
        lit_check("sw_memwrite_state", int'(bus.state), 5);
        lit_check("sw_mem_write_high", int'(bus.mem_write), 1);
        rst = 1'b0;
        #1;
        lit_check("async_rst_mem_write", int'(bus.mem_write), 0);
        lit_check("async_rst_state", int'(bus.state), 0);
        @(posedge clk);
        #1;
        lit_check("held_rst_state", int'(bus.state), 0);
        lit_check("held_rst_pc_write", int'(bus.pc_write), 0);
        rst = 1'b1;
        run_instr(7'b0000011, 1, 0, 0, 0);
        run_instr(7'b0010011, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
